// File: rtl/seg7_count_ctrl.sv
// Push-button sequencer producing a held signed count (-9..+9) for the seven-segment decoder.
// Build option: define SEG7_CTRL_WRAP_EN to wrap at the limits instead of saturating.
module seg7_count_ctrl #(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up_btn,
  input  logic       dn_btn,
  input  logic       clr,
  output logic [4:0] bcd,
  output logic       step,
  output logic       at_lim
);

  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FIRST  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic              r_up_s1, r_up_s2, r_dn_s1, r_dn_s2;
  logic [1:0]        r_state, w_state_nx;
  logic [TW-1:0]     r_timer, w_timer_nx;
  logic              r_dir, w_dir_nx;
  logic              r_lock, w_lock_nx;
  logic signed [4:0] r_bcd, w_bcd_nx;
  logic              r_step, r_at_lim;
  logic              w_req_up, w_req_dn, w_req, w_do_step;

  // One +1/-1 move, bounded at +/-9 either by wrapping or by holding the value.
  function automatic logic signed [4:0] f_bound_step(input logic signed [4:0] v, input logic up);
`ifdef SEG7_CTRL_WRAP_EN
    if (up) return (v == 5'sd9)  ? -5'sd9 : v + 5'sd1;
    else    return (v == -5'sd9) ? 5'sd9  : v - 5'sd1;
`else
    if (up) return (v == 5'sd9)  ? v : v + 5'sd1;
    else    return (v == -5'sd9) ? v : v - 5'sd1;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up_s1 <= 1'b0;
      r_up_s2 <= 1'b0;
      r_dn_s1 <= 1'b0;
      r_dn_s2 <= 1'b0;
    end else begin
      r_up_s1 <= up_btn;
      r_up_s2 <= r_up_s1;
      r_dn_s1 <= dn_btn;
      r_dn_s2 <= r_dn_s1;
    end
  end

  // The lockout keeps a button held through clr from stepping until it is released.
  assign w_req_up = r_up_s2 & ~r_dn_s2 & ~r_lock;
  assign w_req_dn = r_dn_s2 & ~r_up_s2 & ~r_lock;
  assign w_req    = w_req_up | w_req_dn;

  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_dir_nx   = r_dir;
    w_lock_nx  = r_lock & (r_up_s2 | r_dn_s2);
    w_do_step  = 1'b0;
    w_bcd_nx   = r_bcd;
    if (clr) begin
      w_state_nx = S_IDLE;
      w_timer_nx = '0;
      w_lock_nx  = 1'b1;
      w_bcd_nx   = 5'sd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            w_do_step  = 1'b1;
            w_timer_nx = TW'(HOLD_CYCLES - 1);
            w_dir_nx   = w_req_up;
            w_state_nx = S_FIRST;
          end
        end
        S_FIRST, S_REPEAT: begin
          if (!w_req || (w_req_up != r_dir)) begin
            w_state_nx = S_IDLE;
            w_timer_nx = '0;
          end else if (r_timer == '0) begin
            w_do_step  = 1'b1;
            w_timer_nx = TW'(REPEAT_CYCLES - 1);
            w_state_nx = S_REPEAT;
          end else begin
            w_timer_nx = r_timer - TW'(1);
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_timer_nx = '0;
        end
      endcase
      if (w_do_step) w_bcd_nx = f_bound_step(r_bcd, w_req_up);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_dir    <= 1'b0;
      r_lock   <= 1'b0;
      r_bcd    <= 5'sd0;
      r_step   <= 1'b0;
      r_at_lim <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_timer  <= w_timer_nx;
      r_dir    <= w_dir_nx;
      r_lock   <= w_lock_nx;
      r_bcd    <= w_bcd_nx;
      r_step   <= (w_bcd_nx != r_bcd);
      r_at_lim <= (w_bcd_nx == 5'sd9) || (w_bcd_nx == -5'sd9);
    end
  end

  assign bcd    = r_bcd;
  assign step   = r_step;
  assign at_lim = r_at_lim;

endmodule

// File: tb/tb_seg7_count_ctrl.sv
// Directed bench for seg7_count_ctrl (saturating build, HOLD_CYCLES=8, REPEAT_CYCLES=4).
module tb_seg7_count_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up_btn, dn_btn, clr;
  logic [4:0] bcd;
  logic       step, at_lim;

  int n_tests = 0;
  int n_fail  = 0;
  int ns;

  seg7_count_ctrl #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .up_btn (up_btn),
    .dn_btn (dn_btn),
    .clr    (clr),
    .bcd    (bcd),
    .step   (step),
    .at_lim (at_lim)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic u, input logic d, input int nh, input int nl, output int n);
    n = 0;
    up_btn = u;
    dn_btn = d;
    repeat (nh) begin tick(); n += int'(step); end
    up_btn = 1'b0;
    dn_btn = 1'b0;
    repeat (nl) begin tick(); n += int'(step); end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; up_btn = 1'b0; dn_btn = 1'b0; clr = 1'b0;
    repeat (3) tick();
    check("rst_bcd", bcd, 5'd0);
    check("rst_step", step, 0);
    check("rst_lim", at_lim, 0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle_hold", bcd, 5'd0);

    // single short press
    press(1'b1, 1'b0, 3, 12, ns);
    check("single_steps", ns, 1);
    check("single_bcd", bcd, 5'd1);

    do_clr();
    check("clr_bcd", bcd, 5'd0);
    check("clr_step_nz", step, 1);
    do_clr();
    check("clr_step_zero", step, 0);

    // hold: steps at +3, +11, then every 4 cycles, saturating at +9
    up_btn = 1'b1;
    ns = 0;
    for (int i = 1; i <= 48; i++) begin
      tick();
      ns += int'(step);
      if (i == 2)  check("hold_lat2", bcd, 5'd0);
      if (i == 3)  check("hold_lat3", bcd, 5'd1);
      if (i == 10) check("hold_t10", bcd, 5'd1);
      if (i == 11) check("hold_t11", bcd, 5'd2);
      if (i == 14) check("hold_t14", bcd, 5'd2);
      if (i == 15) check("hold_t15", bcd, 5'd3);
      if (i == 38) check("hold_lim38", at_lim, 0);
      if (i == 39) check("hold_lim39", at_lim, 1);
    end
    check("hold_steps", ns, 9);
    check("hold_bcd", bcd, 5'd9);
    check("hold_lim", at_lim, 1);

    // asynchronous reset mid-hold, then re-entry as a fresh press
    #2 rst_n = 1'b0;
    #1;
    check("arst_bcd", bcd, 5'd0);
    check("arst_step", step, 0);
    check("arst_lim", at_lim, 0);
    tick();
    #2 rst_n = 1'b1;
    tick(); tick();
    check("arst_rel2", bcd, 5'd0);
    tick();
    check("arst_rel3", bcd, 5'd1);
    check("arst_rel3_step", step, 1);
    up_btn = 1'b0;
    repeat (5) tick();

    // clr while held at +5
    do_clr();
    up_btn = 1'b1;
    repeat (23) tick();
    check("pre_clr_bcd", bcd, 5'd5);
    clr = 1'b1;
    tick();
    check("clr5_bcd", bcd, 5'd0);
    check("clr5_step", step, 1);
    clr = 1'b0;
    ns = 0;
    repeat (20) begin tick(); ns += int'(step); end
    check("clr_lock_steps", ns, 0);
    check("clr_lock_bcd", bcd, 5'd0);
    up_btn = 1'b0;
    repeat (4) tick();
    press(1'b1, 1'b0, 3, 6, ns);
    check("repress_steps", ns, 1);
    check("repress_bcd", bcd, 5'd1);

    // negative side down to -9
    do_clr();
    ns = 0;
    for (int k = 0; k < 9; k++) begin
      int n1;
      press(1'b0, 1'b1, 3, 6, n1);
      ns += n1;
    end
    check("neg_steps", ns, 9);
    check("neg_bcd", bcd, 5'b10111);
    check("neg_lim", at_lim, 1);
    press(1'b0, 1'b1, 3, 6, ns);
    check("neg_sat_steps", ns, 0);
    check("neg_sat_bcd", bcd, 5'b10111);

    // both buttons together
    press(1'b1, 1'b1, 20, 4, ns);
    check("conflict_steps", ns, 0);
    check("conflict_bcd", bcd, 5'b10111);

    press(1'b1, 1'b0, 3, 6, ns);
    check("up_from_min", bcd, 5'b11000);
    check("up_from_min_lim", at_lim, 0);

    // direction change while held
    up_btn = 1'b1;
    repeat (3) tick();
    check("dir_up", bcd, 5'b11001);
    repeat (2) tick();
    up_btn = 1'b0;
    dn_btn = 1'b1;
    repeat (3) tick();
    check("dir_gap", bcd, 5'b11001);
    check("dir_gap_step", step, 0);
    tick();
    check("dir_dn", bcd, 5'b11000);
    check("dir_dn_step", step, 1);
    dn_btn = 1'b0;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
